bank_group_scheduler: RTL

Rank-level scheduler above the four per-bank-group drain FSMs in the back-end arbiter. It picks one bank group at a time in round-robin order and drives that group's `start` (continue) input. It gates `start` so consecutive column commands respect tCCD_L (same bank group) and tCCD_S (different bank group). It caps each burst at MAX_BURST commands so one busy group cannot starve the others.

---
 rtl/arbiter_pkg.sv | 22 ++
 rtl/rr_picker.sv | 34 +++
 rtl/bank_group_scheduler.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/arbiter_pkg.sv
// Shared types and default timing constants for the back-end arbiter.
// The rank-level bank group scheduler and its round-robin picker import this.
package arbiter_pkg;

  // Number of bank groups on the rank.
  localparam int NUM_BG = 4;

  // Default column-to-column spacing, in clock cycles.
  localparam int DEF_TCCD_S = 4;   // different bank group
  localparam int DEF_TCCD_L = 6;   // same bank group

  // Commands allowed per grant before another requester forces a handover.
  localparam int DEF_MAX_BURST = 16;

  // Scheduler states: no grant, burst in progress, one-cycle handover.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT  = 2'd1,
    SWITCH = 2'd2
  } sched_state_e;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: returns the first set bit of bg_req,
// searching upward from rr_ptr and wrapping modulo NUM_BG.
module rr_picker #(
  parameter int  NUM_BG = arbiter_pkg::NUM_BG,
  localparam int IDX_W  = $clog2(NUM_BG)
) (
  input  logic [NUM_BG-1:0] bg_req,
  input  logic [IDX_W-1:0]  rr_ptr,
  output logic              valid,
  output logic [IDX_W-1:0]  idx
);

  int               pos;
  logic [IDX_W-1:0] pos_idx;

  // Walk offsets from farthest to nearest so the nearest requester wins.
  always_comb begin
    // NOTE: every output and temporary gets a value before any branch;
    // a path that leaves one unassigned would infer a latch.
    valid   = 1'b0;
    idx     = '0;
    pos     = 0;
    pos_idx = '0;
    for (int k = NUM_BG - 1; k >= 0; k--) begin
      pos     = (int'(rr_ptr) + k) % NUM_BG;
      pos_idx = IDX_W'(pos);
      if (bg_req[pos_idx]) begin
        valid = 1'b1;
        idx   = pos_idx;
      end
    end
  end

endmodule

// File: rtl/bank_group_scheduler.sv
// Rank-level scheduler above the per-bank-group drain FSMs. Grants one bank
// group at a time in round-robin order, paces its start so column commands
// respect tCCD_L/tCCD_S, and forces a handover after MAX_BURST commands when
// another group is waiting.
module bank_group_scheduler #(
  parameter int  NUM_BG    = arbiter_pkg::NUM_BG,
  parameter int  TCCD_S    = arbiter_pkg::DEF_TCCD_S,
  parameter int  TCCD_L    = arbiter_pkg::DEF_TCCD_L,
  parameter int  MAX_BURST = arbiter_pkg::DEF_MAX_BURST,
  localparam int BG_W      = $clog2(NUM_BG)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_BG-1:0] bg_req,
  input  logic [NUM_BG-1:0] bg_en,
  input  logic [NUM_BG-1:0] bg_done,
  output logic [NUM_BG-1:0] bg_start,
  output logic [BG_W-1:0]   grant_idx,
  output logic              busy
);

  import arbiter_pkg::*;

  localparam int CNT_W   = $clog2(MAX_BURST + 1);
  localparam int SINCE_W = $clog2(TCCD_L + 1);

  localparam logic [CNT_W-1:0]   BURST_CAP = CNT_W'(MAX_BURST);
  localparam logic [SINCE_W-1:0] GAP_SAME  = SINCE_W'(TCCD_L);
  localparam logic [SINCE_W-1:0] GAP_DIFF  = SINCE_W'(TCCD_S);
  localparam logic [BG_W-1:0]    LAST_IDX  = BG_W'(NUM_BG - 1);

  // Registered state.
  sched_state_e        state_q;
  sched_state_e        state_d;
  logic [BG_W-1:0]     grant_q;
  logic [BG_W-1:0]     rr_ptr_q;
  logic [BG_W-1:0]     last_bg_q;
  logic [CNT_W-1:0]    burst_cnt_q;
  logic [SINCE_W-1:0]  since_q;

  // Picker results.
  logic                pick_valid;
  logic [BG_W-1:0]     pick_idx;

  // Decoded per-cycle conditions.
  logic [NUM_BG-1:0]   grant_bit;
  logic [SINCE_W-1:0]  gap_need;
  logic                gap_ok;
  logic                at_cap;
  logic                other_req;
  logic                forced_sw;
  logic                req_held;
  logic                issue;
  logic                burst_end;
  logic [BG_W-1:0]     rr_next;

  rr_picker #(
    .NUM_BG (NUM_BG)
  ) u_picker (
    .bg_req (bg_req),
    .rr_ptr (rr_ptr_q),
    .valid  (pick_valid),
    .idx    (pick_idx)
  );

  // Permit decode: start is driven only from registered state, except for
  // the forced-handover gate, which must drop start in the cycle another
  // group is seen waiting at the burst cap.
  always_comb begin
    grant_bit = NUM_BG'(1) << grant_q;
    gap_need  = (grant_q == last_bg_q) ? GAP_SAME : GAP_DIFF;
    gap_ok    = (since_q >= gap_need);
    at_cap    = (burst_cnt_q == BURST_CAP);
    other_req = |(bg_req & ~grant_bit);
    forced_sw = (state_q == GRANT) && at_cap && other_req;
    req_held  = |(bg_req & grant_bit);
    bg_start  = '0;
    if ((state_q == GRANT) && gap_ok && !forced_sw && !rst) begin
      bg_start = grant_bit;
    end
    // A group's done is meaningful only while it is started; an idle group
    // FSM holds done high.
    issue     = |(bg_start & bg_en);
    burst_end = |(bg_start & bg_done & ~bg_en);
    rr_next   = (grant_q == LAST_IDX) ? '0 : grant_q + BG_W'(1);
  end

  // Next-state logic and the busy flag.
  always_comb begin
    state_d = state_q;
    busy    = (state_q != IDLE);
    unique case (state_q)
      IDLE: begin
        if (pick_valid) begin
          state_d = GRANT;
        end
      end
      GRANT: begin
        // Burst end, forced handover and a withdrawn request all hand over
        // the same way; a cap hit coinciding with burst end is just burst end.
        if (burst_end || forced_sw || !req_held) begin
          state_d = SWITCH;
        end
      end
      SWITCH: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State register plus grant, round-robin pointer and spacing trackers.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      state_q     <= IDLE;
      grant_q     <= '0;
      rr_ptr_q    <= '0;
      last_bg_q   <= '0;
      burst_cnt_q <= '0;
      // Start saturated so the first command after reset is never stalled.
      since_q     <= GAP_SAME;
    end else begin
      state_q <= state_d;

      if ((state_q == IDLE) && pick_valid) begin
        grant_q     <= pick_idx;
        burst_cnt_q <= '0;
      end else if (issue && !at_cap) begin
        burst_cnt_q <= burst_cnt_q + CNT_W'(1);
      end

      // Spacing counter keeps running through SWITCH and IDLE so the
      // handover cycles count toward tCCD.
      if (issue) begin
        last_bg_q <= grant_q;
        since_q   <= SINCE_W'(1);
      end else if (since_q < GAP_SAME) begin
        since_q <= since_q + SINCE_W'(1);
      end

      if (state_q == SWITCH) begin
        rr_ptr_q <= rr_next;
      end
    end
  end

  assign grant_idx = grant_q;

endmodule
